// File: rtl/board_generator.sv
// board_generator: fills a SIZE x SIZE board with pseudo-random colours, one cell per clock,
// in row-major order, through a single write port.
// Optional macro BOARD_GEN_HIST_EN adds the HIST output (per-colour cell counters).
module board_generator #(
  parameter int unsigned MAX_SIZE     = 26,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  SIZE,
  input  logic [3:0]  COLOR_NUM,
  input  logic [15:0] SEED,
  output logic        WR_EN,
  output logic [4:0]  WR_ROW,
  output logic [4:0]  WR_COL,
  output logic [2:0]  WR_COLOR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
`ifdef BOARD_GEN_HIST_EN
  ,
  output logic [79:0] HIST
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StGen, StDone} state_e;

  state_e      state_q;
  logic [4:0]  size_q;
  logic [3:0]  cnum_q;
  logic [4:0]  row_q;
  logic [4:0]  col_q;
  logic [15:0] lfsr_q;
  logic        err_q;

  logic        size_legal;
  logic [3:0]  cnum_clamped;
  logic [15:0] seed_sel;
  logic [15:0] lfsr_next;
  logic        col_last;
  logic        row_last;
  logic [8:0]  color_prod;

  // Request decode: legality of SIZE, clamped colour count, zero-seed substitution.
  always_comb begin
    size_legal = (SIZE != 5'd0) && (32'(SIZE) <= MAX_SIZE);
    if (COLOR_NUM < 4'd2) begin
      cnum_clamped = 4'd2;
    end else if (COLOR_NUM > 4'd8) begin
      cnum_clamped = 4'd8;
    end else begin
      cnum_clamped = COLOR_NUM;
    end
    seed_sel = (SEED == 16'd0) ? DEFAULT_SEED : SEED;
  end

  // LFSR step, cell-position flags and colour scaling from the registered state.
  always_comb begin
    lfsr_next  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    col_last   = (col_q == size_q - 5'd1);
    row_last   = (row_q == size_q - 5'd1);
    // 6-bit random fraction times cnum_q, top bits kept: result is always < cnum_q.
    color_prod = {3'b000, lfsr_q[5:0]} * {5'b00000, cnum_q};
  end

  // Main FSM: state, geometry latches, row/col counters, LFSR and sticky error flag.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= StIdle;
      size_q  <= 5'd0;
      cnum_q  <= 4'd2;
      row_q   <= 5'd0;
      col_q   <= 5'd0;
      lfsr_q  <= DEFAULT_SEED;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            if (size_legal) begin
              state_q <= StLoad;
              err_q   <= 1'b0;
            end else begin
              // Illegal size: report through DONE with ERR, no writes.
              state_q <= StDone;
              err_q   <= 1'b1;
            end
          end
        end
        StLoad: begin
          size_q  <= SIZE;
          cnum_q  <= cnum_clamped;
          lfsr_q  <= seed_sel;
          row_q   <= 5'd0;
          col_q   <= 5'd0;
          err_q   <= 1'b0;
          state_q <= StGen;
        end
        StGen: begin
          lfsr_q <= lfsr_next;
          if (col_last) begin
            col_q <= 5'd0;
            if (row_last) begin
              state_q <= StDone;
            end else begin
              row_q <= row_q + 5'd1;
            end
          end else begin
            col_q <= col_q + 5'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output decode; every output depends only on registered state.
  always_comb begin
    WR_EN    = (state_q == StGen);
    WR_ROW   = (state_q == StGen) ? row_q : 5'd0;
    WR_COL   = (state_q == StGen) ? col_q : 5'd0;
    WR_COLOR = (state_q == StGen) ? color_prod[8:6] : 3'd0;
    BUSY     = (state_q != StIdle);
    DONE     = (state_q == StDone);
    ERR      = err_q;
  end

`ifdef BOARD_GEN_HIST_EN
  logic [9:0] hist_q [8];

  // Per-colour counters: cleared in LOAD, bumped for the colour written each GEN cycle.
  always_ff @(posedge CLOCK) begin
    if (RESET || (state_q == StLoad)) begin
      for (int k = 0; k < 8; k++) begin
        hist_q[k] <= 10'd0;
      end
    end else if (state_q == StGen) begin
      hist_q[color_prod[8:6]] <= hist_q[color_prod[8:6]] + 10'd1;
    end
  end

  // Pack counters, colour k at bits [10k+9:10k].
  always_comb begin
    HIST = '0;
    for (int k = 0; k < 8; k++) begin
      HIST[k*10 +: 10] = hist_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_board_generator.sv
// Self-checking bench for board_generator: table of runs checked against a reference
// colour/geometry model, plus hand-written reset, first-run and abort sequences.
module tb_board_generator;

  logic        clk;
  logic        RESET;
  logic        START;
  logic [4:0]  SIZE;
  logic [3:0]  COLOR_NUM;
  logic [15:0] SEED;
  logic        WR_EN;
  logic [4:0]  WR_ROW;
  logic [4:0]  WR_COL;
  logic [2:0]  WR_COLOR;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
`ifdef BOARD_GEN_HIST_EN
  logic [79:0] HIST;
`endif

  int checks = 0;
  int errors = 0;

  board_generator dut (
    .CLOCK     (clk),
    .RESET     (RESET),
    .START     (START),
    .SIZE      (SIZE),
    .COLOR_NUM (COLOR_NUM),
    .SEED      (SEED),
    .WR_EN     (WR_EN),
    .WR_ROW    (WR_ROW),
    .WR_COL    (WR_COL),
    .WR_COLOR  (WR_COLOR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
`ifdef BOARD_GEN_HIST_EN
    ,
    .HIST      (HIST)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // mode 0: plain run; 1: re-START with SIZE=2 at write 20; 2: RESET at write 7.
  task automatic run(input logic [4:0] sz, input logic [3:0] cn, input logic [15:0] sd,
                     input int mode, output int nwr, output int dcyc, output int sig,
                     output logic err_at_done);
    logic [15:0] lm;
    logic [3:0]  cm;
    logic [8:0]  prod;
    int          er;
    int          ec;
    int          bound;
    int          quiet;
    int          hcnt [8];
    lm = (sd == 16'd0) ? 16'hACE1 : sd;
    cm = (cn < 4'd2) ? 4'd2 : ((cn > 4'd8) ? 4'd8 : cn);
    er = 0;
    ec = 0;
    nwr = 0;
    dcyc = -1;
    sig = 0;
    err_at_done = 1'b0;
    bound = int'(sz) * int'(sz) + 8;
    for (int k = 0; k < 8; k++) hcnt[k] = 0;
    @(negedge clk);
    START = 1'b1;
    SIZE = sz;
    COLOR_NUM = cn;
    SEED = sd;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      @(negedge clk);
      START = 1'b0;
      chk("busy_in_run", BUSY, 1);
      if (WR_EN) begin
        nwr++;
        if (nwr == 1) chk("err_cleared", ERR, 0);
        chk("wr_row", WR_ROW, er);
        chk("wr_col", WR_COL, ec);
        prod = {3'b000, lm[5:0]} * {5'b00000, cm};
        chk("wr_color", WR_COLOR, prod[8:6]);
        sig = sig * 31 + int'(WR_COLOR) + 1;
        hcnt[WR_COLOR]++;
        lm = {lm[0] ^ lm[2] ^ lm[3] ^ lm[5], lm[15:1]};
        if (ec == int'(sz) - 1) begin
          ec = 0;
          er++;
        end else begin
          ec++;
        end
        if (mode == 1 && nwr == 20) begin
          START = 1'b1;
          SIZE = 5'd2;
        end
        if (mode == 2 && nwr == 7) begin
          RESET = 1'b1;
          @(negedge clk);
          chk("abort_wr_en", WR_EN, 0);
          chk("abort_busy", BUSY, 0);
          chk("abort_done", DONE, 0);
          RESET = 1'b0;
          quiet = 0;
          repeat (6) begin
            @(negedge clk);
            if (WR_EN || DONE || BUSY) quiet++;
          end
          chk("abort_quiet", quiet, 0);
          break;
        end
      end
      if (DONE) begin
        dcyc = cyc;
        err_at_done = ERR;
        chk("wr_en_at_done", WR_EN, 0);
`ifdef BOARD_GEN_HIST_EN
        if (nwr > 0) begin
          int hsum;
          hsum = 0;
          for (int k = 0; k < 8; k++) begin
            chk("hist_bin", HIST[k*10 +: 10], hcnt[k]);
            hsum += int'(HIST[k*10 +: 10]);
          end
          chk("hist_sum", hsum, int'(sz) * int'(sz));
        end
`endif
        break;
      end
    end
    if (mode != 2) begin
      @(negedge clk);
      chk("idle_busy", BUSY, 0);
      chk("idle_done", DONE, 0);
      chk("idle_wr_en", WR_EN, 0);
    end
  endtask

  typedef struct {
    logic [4:0]  sz;
    logic [3:0]  cn;
    logic [15:0] sd;
    int          mode;
    int          exp_wr;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t v [NV];
  int   sigs [NV];

  initial begin
    int   nwr;
    int   dcyc;
    int   sig;
    logic errd;
    int   exp_row [7];
    int   exp_col [7];
    int   exp_col_v [7];
    int   exp_wen [7];

    v[0]  = '{5'd2,  4'd4,  16'h0000, 0, 4,   6,   1'b0};
    v[1]  = '{5'd26, 4'd8,  16'h1234, 0, 676, 678, 1'b0};
    v[2]  = '{5'd26, 4'd8,  16'h1234, 0, 676, 678, 1'b0};
    v[3]  = '{5'd6,  4'd1,  16'hABCD, 0, 36,  38,  1'b0};
    v[4]  = '{5'd6,  4'd15, 16'hABCD, 0, 36,  38,  1'b0};
    v[5]  = '{5'd0,  4'd4,  16'h0000, 0, 0,   1,   1'b1};
    v[6]  = '{5'd27, 4'd4,  16'h0000, 0, 0,   1,   1'b1};
    v[7]  = '{5'd3,  4'd5,  16'h0001, 0, 9,   11,  1'b0};
    v[8]  = '{5'd10, 4'd3,  16'hBEEF, 1, 100, 102, 1'b0};
    v[9]  = '{5'd6,  4'd4,  16'h5555, 0, 36,  38,  1'b0};
    v[10] = '{5'd6,  4'd4,  16'h5555, 2, 7,   -1,  1'b0};
    v[11] = '{5'd6,  4'd4,  16'h5555, 0, 36,  38,  1'b0};
    v[12] = '{5'd31, 4'd4,  16'h0000, 0, 0,   1,   1'b1};
    v[13] = '{5'd1,  4'd2,  16'hFFFF, 0, 1,   3,   1'b0};

    RESET = 1'b1;
    START = 1'b0;
    SIZE = 5'd0;
    COLOR_NUM = 4'd0;
    SEED = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", WR_EN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_row", WR_ROW, 0);
    chk("rst_color", WR_COLOR, 0);
    RESET = 1'b0;
    @(negedge clk);

    // First run by hand: SIZE=2, 4 colours, default seed; colours 2,3,3,1.
    exp_wen   = '{0, 1, 1, 1, 1, 0, 0};
    exp_row   = '{0, 0, 0, 1, 1, 0, 0};
    exp_col   = '{0, 0, 1, 0, 1, 0, 0};
    exp_col_v = '{0, 2, 3, 3, 1, 0, 0};
    START = 1'b1;
    SIZE = 5'd2;
    COLOR_NUM = 4'd4;
    SEED = 16'd0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      START = 1'b0;
      chk("seq_wr_en", WR_EN, exp_wen[c-1]);
      chk("seq_busy", BUSY, (c <= 6) ? 1 : 0);
      chk("seq_done", DONE, (c == 6) ? 1 : 0);
      if (exp_wen[c-1] == 1) begin
        chk("seq_row", WR_ROW, exp_row[c-1]);
        chk("seq_col", WR_COL, exp_col[c-1]);
        chk("seq_color", WR_COLOR, exp_col_v[c-1]);
      end
    end

    for (int i = 0; i < NV; i++) begin
      run(v[i].sz, v[i].cn, v[i].sd, v[i].mode, nwr, dcyc, sig, errd);
      chk("vec_writes", nwr, v[i].exp_wr);
      chk("vec_done_cycle", dcyc, v[i].exp_done);
      chk("vec_err", errd, v[i].exp_err);
      sigs[i] = sig;
    end
    chk("repeat_seed_stream", sigs[2], sigs[1]);
    chk("post_abort_stream", sigs[11], sigs[9]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_generator.md
Name: board_generator

Overview:
- Upstream stage of game_logic. Fills the initial board that game_logic copies into GAME_BOARD when a new game starts.
- On a START pulse it walks every cell of a SIZE×SIZE board in row-major order, one cell per clock. Each cell gets a pseudo-random colour in 0..COLOR_NUM-1, taken from a 16-bit LFSR.
- Cells go out through a single write port into the board storage. DONE tells the top-level controller it may assert START_NEW_GAME.

Parameters:
- MAX_SIZE, 26, largest legal board dimension; sets the row/col counter range.
- DEFAULT_SEED, 16'hACE1, LFSR seed used when SEED input is 0.

Ports:
- CLOCK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request generation; sampled only in IDLE.
- SIZE  input  5  board dimension; legal range 1..MAX_SIZE.
- COLOR_NUM  input  4  number of colours; legal range 2..8.
- SEED  input  16  LFSR seed; 0 selects DEFAULT_SEED.
- WR_EN  output  1  cell write strobe.
- WR_ROW  output  5  row of the cell being written.
- WR_COL  output  5  column of the cell being written.
- WR_COLOR  output  3  colour of the cell being written.
- BUSY  output  1  high in LOAD, GEN and DONE.
- DONE  output  1  one-cycle pulse after the final cell is written.
- ERR  output  1  sticky; set when an illegal SIZE is requested.

Behaviour:
- Reset: all outputs are 0 on the first edge with RESET=1; state=IDLE, LFSR=DEFAULT_SEED. Reset mid-generation aborts immediately: no further WR_EN and no DONE.
- States: IDLE, LOAD, GEN, DONE.
- IDLE:
  - START=1 and SIZE in 1..MAX_SIZE → LOAD.
  - START=1 and SIZE=0 or SIZE>MAX_SIZE → DONE with ERR set; no writes occur.
  - START=0 → stay in IDLE.
- LOAD (exactly 1 cycle):
  - Latch SIZE into size_q.
  - Latch COLOR_NUM into cnum_q, clamped: values <2 become 2, values >8 become 8.
  - Load LFSR with SEED, or with DEFAULT_SEED if SEED=0.
  - row=col=0; clear ERR. Then → GEN.
- GEN (one cell per cycle):
  - WR_EN=1, WR_ROW=row, WR_COL=col.
  - WR_COLOR=(lfsr[5:0]*cnum_q)>>6, computed at 9-bit product width, so the result is always <cnum_q.
  - Outputs are combinational from registered state: a write is valid in the same cycle WR_EN is high.
  - Each GEN cycle the LFSR advances once: fb=l[0]^l[2]^l[3]^l[5]; l={fb,l[15:1]}.
  - Counter advance: col++; when col==size_q-1, col←0 and row++.
  - On the cell (size_q-1, size_q-1) → DONE.
  - Total write cycles are exactly size_q²; START to DONE latency is size_q²+2 cycles.
- DONE (exactly 1 cycle): DONE=1, WR_EN=0. Then → IDLE.
- START while BUSY is ignored and is not queued.
- SIZE, COLOR_NUM and SEED changes after LOAD have no effect on the run in progress.
- Rows and columns never exceed size_q-1.
- The LFSR is never zero: a zero seed is replaced by DEFAULT_SEED.
- ERR: set only on an illegal-SIZE start; cleared only by a legal start (in LOAD) or by RESET.

Optional Feature:
- Macro: BOARD_GEN_HIST_EN.
- When defined:
  - Adds output HIST[79:0]: eight 10-bit counters, colour k at bits [10k+9:10k].
  - Counters clear in LOAD; the counter for WR_COLOR increments on every WR_EN cycle.
  - Values are stable and valid from the DONE cycle until the next LOAD.
  - The sum of all counters equals size_q².
- When undefined: no HIST port and no counter logic; all other behaviour is identical.

Test Plan:
- RESET, then START with SIZE=2, COLOR_NUM=4, SEED=0 → one LOAD cycle, then four WR_EN cycles at (0,0),(0,1),(1,0),(1,1). The first two colours are 2 and 3 (LFSR 0xACE1, then 0x5670). DONE pulses exactly on cycle 6 after START; BUSY is high for cycles 1-6.
- SIZE=26, COLOR_NUM=8, SEED=16'h1234 → exactly 676 writes with every WR_COLOR ≤7; two runs with the same seed give bit-identical streams. With BOARD_GEN_HIST_EN, the HIST sum is 676.
- SIZE=6, COLOR_NUM=1, then COLOR_NUM=15 → every WR_COLOR is in {0,1} and then in 0..7 respectively (clamping). Exactly 36 writes each run.
- SIZE=0, and separately SIZE=27 → no WR_EN, DONE one cycle after START, ERR=1. A following legal start clears ERR in its LOAD cycle.
- During a SIZE=10 run, assert START again and change SIZE to 2 at write #20 → ignored; 100 writes total with the original geometry.
- Assert RESET at write #7 of a SIZE=6 run → WR_EN=0 from the next cycle, no DONE, BUSY=0. A following START behaves exactly as a fresh run.
